rf_wport_sched: RTL
===================

Name: rf_wport_sched

Overview:
- Schedules the single register-file write port of the ID stage between two sources: the in-order pipeline write-back and the out-of-order results of the multi-cycle mul/div unit (MDU).
- Buffers MDU results that lose arbitration.
- Keeps a per-register busy scoreboard for MDU destinations and generates the ID-stage stall for RAW/WAW hazards and for write-port starvation.

Parameters:
DEPTH, 2, MDU result buffer entries (power of 2, >=2)
STARVE_MAX, 4, cycles a buffered head may wait before a starvation stall is forced

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
pipe_we  input  1  pipeline WB write enable
pipe_wr  input  5  pipeline WB destination
pipe_wd  input  32  pipeline WB data
mdu_issue  input  1  MDU op leaves ID this cycle (not stalled)
mdu_issue_rd  input  5  destination of the issued MDU op
mdu_valid  input  1  MDU result valid
mdu_rd  input  5  MDU result destination
mdu_data  input  32  MDU result data
mdu_ready  output  1  buffer can accept a result
id_rs1  input  5  ID source 1
id_rs2  input  5  ID source 2
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_wr  input  5  ID destination
id_we  input  1  ID instruction writes id_wr
stall_id  output  1  hold IF/ID, inject bubble into EX
rf_we  output  1  register-file write enable
rf_wr  output  5  register-file write address
rf_wd  output  32  register-file write data
buf_count  output  2  buffer occupancy, widened to clog2(DEPTH)+1

Behaviour:
Reset (async, while rst=1):
- Busy[31:0]=0, buffer empty, buf_count=0, wait counter=0.
- mdu_ready=0, stall_id=0, rf_we=0, rf_wr=0, rf_wd=0.
- First edge after release: mdu_ready=1.
- An MDU op in flight at reset is lost. The MDU is reset by the same rst.

Write-port arbitration (combinational, same cycle):
- A pipeline write is effective when pipe_we=1 and pipe_wr!=0. It has priority.
- Otherwise, if the buffer is non-empty, the buffer head drives rf_*. It pops at the edge.
- Otherwise, if mdu_valid=1 and mdu_rd!=0, the MDU result bypasses the buffer to rf_* and is not enqueued.
- Otherwise rf_we=0.

Buffer:
- FIFO. mdu_ready = (buf_count<DEPTH).
- Push when mdu_valid and mdu_ready, and the result was not bypassed.
- Pop on the same edge as a push is allowed. Count is unchanged and order is preserved.
- A result with mdu_rd=0 is accepted (handshake completes) but is never enqueued or written.
- When full, mdu_ready=0 and the MDU must hold its result.

Scoreboard:
- On the edge where mdu_issue=1 and mdu_issue_rd!=0, busy[mdu_issue_rd] is set.
- busy[r] is cleared on the edge where an MDU-sourced write (head or bypass) to r is on rf_*.
- Set and clear of the same r on the same edge: set wins.
- stall_id = (id_use_rs1 & busy[id_rs1]) | (id_use_rs2 & busy[id_rs2]) | (id_we & busy[id_wr]) | starve.
- x0 is never busy.
- There is no bypass from rf_wd to ID. A reader stalls through the write cycle and proceeds the cycle after.

Starvation:
- The wait counter increments each cycle the buffer is non-empty and the pipeline wins the port.
- It resets to 0 on a pop or when the buffer is empty. It saturates at STARVE_MAX.
- starve = (counter==STARVE_MAX). It holds stall_id high until the head pops; the bubbles reach WB and free the port.

Invariant: a pipeline write to r while busy[r]=1 cannot occur (prevented by the WAW stall). The bench asserts this.

Test Plan:
- Reset: assert rst mid-cycle with 2 entries buffered -> buf_count=0, rf_we=0, busy=0 immediately; mdu_ready=1 one edge after release.
- Bypass: idle pipe, mdu_valid with rd=5, data=0x1234 -> same cycle rf_we=1, rf_wr=5, rf_wd=0x1234; busy[5] clears; buf_count stays 0.
- Conflict: pipe writes x3=0xA while MDU delivers x7=0xB -> rf gets x3 first; next pipe-idle cycle rf gets x7=0xB; buf_count goes 1 then 0.
- RAW/WAW: issue MDU to x9, then ID reads rs1=x9 -> stall_id=1 until the cycle after x9 is written. ID with id_we=1, id_wr=x9 stalls the same way. rs1=x0 never stalls.
- Full buffer: pipe writes every cycle, 3 MDU results, DEPTH=2 -> mdu_ready=0 on the third result; starve fires after 4 waiting cycles; the buffer drains FIFO-ordered.
- x0 and simultaneous set/clear: MDU result with rd=0 is accepted and not written. An issue to x4 on the same edge as the x4 write -> busy[4]=1 afterward.

Source files
------------

// File: rtl/rf_wport_sched_if.sv
// rtl/rf_wport_sched_if.sv - write-port scheduler signal bundle
// Pipeline WB, MDU result handshake, ID hazard query and register-file write port.
interface rf_wport_sched_if #(
    parameter int DEPTH = 2
);
    logic                      pipe_we;
    logic [4:0]                pipe_wr;
    logic [31:0]               pipe_wd;
    logic                      mdu_issue;
    logic [4:0]                mdu_issue_rd;
    logic                      mdu_valid;
    logic [4:0]                mdu_rd;
    logic [31:0]               mdu_data;
    logic                      mdu_ready;
    logic [4:0]                id_rs1;
    logic [4:0]                id_rs2;
    logic                      id_use_rs1;
    logic                      id_use_rs2;
    logic [4:0]                id_wr;
    logic                      id_we;
    logic                      stall_id;
    logic                      rf_we;
    logic [4:0]                rf_wr;
    logic [31:0]               rf_wd;
    logic [$clog2(DEPTH):0]    buf_count;

    modport master (
        output pipe_we, pipe_wr, pipe_wd, mdu_issue, mdu_issue_rd,
               mdu_valid, mdu_rd, mdu_data,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_wr, id_we,
        input  mdu_ready, stall_id, rf_we, rf_wr, rf_wd, buf_count
    );

    modport slave (
        input  pipe_we, pipe_wr, pipe_wd, mdu_issue, mdu_issue_rd,
               mdu_valid, mdu_rd, mdu_data,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_wr, id_we,
        output mdu_ready, stall_id, rf_we, rf_wr, rf_wd, buf_count
    );
endinterface

// File: rtl/rf_wport_sched.sv
// rtl/rf_wport_sched.sv - register-file write-port scheduler
// Arbitrates pipeline WB vs MDU results, buffers losers, tracks MDU busy regs and ID stalls.
module rf_wport_sched #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    rf_wport_sched_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    // live holds every output quiet until the first edge after reset release
    logic          live;
    logic [31:0]   busy;
    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [SW-1:0] wait_cnt;

    logic          empty;
    logic          pipe_win;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          starve;
    logic          clr_en;
    logic [4:0]    clr_rd;
    logic [31:0]   busy_next;

    always_comb begin
        empty         = (count == '0);
        bus.mdu_ready = live && (count < CW'(DEPTH));
        pipe_win      = live && bus.pipe_we && (bus.pipe_wr != 5'd0);
        pop           = live && !pipe_win && !empty;
        bypass        = live && !pipe_win && empty && bus.mdu_valid && (bus.mdu_rd != 5'd0);
        push          = bus.mdu_valid && bus.mdu_ready && !bypass && (bus.mdu_rd != 5'd0);
        starve        = (wait_cnt == SW'(STARVE_MAX));
        bus.buf_count = count;
    end

    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_wr = 5'd0;
        bus.rf_wd = 32'd0;
        if (pipe_win) begin
            bus.rf_we = 1'b1;
            bus.rf_wr = bus.pipe_wr;
            bus.rf_wd = bus.pipe_wd;
        end else if (pop) begin
            bus.rf_we = 1'b1;
            bus.rf_wr = q_rd[rptr];
            bus.rf_wd = q_data[rptr];
        end else if (bypass) begin
            bus.rf_we = 1'b1;
            bus.rf_wr = bus.mdu_rd;
            bus.rf_wd = bus.mdu_data;
        end
    end

    // A same-edge issue to the register being retired must leave it busy
    always_comb begin
        clr_en    = pop || bypass;
        clr_rd    = pop ? q_rd[rptr] : bus.mdu_rd;
        busy_next = busy;
        if (clr_en)
            busy_next[clr_rd] = 1'b0;
        if (live && bus.mdu_issue && (bus.mdu_issue_rd != 5'd0))
            busy_next[bus.mdu_issue_rd] = 1'b1;
    end

    always_comb begin
        bus.stall_id = live && ((bus.id_use_rs1 && busy[bus.id_rs1]) ||
                                (bus.id_use_rs2 && busy[bus.id_rs2]) ||
                                (bus.id_we      && busy[bus.id_wr])  ||
                                starve);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live     <= 1'b0;
            busy     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            live  <= 1'b1;
            busy  <= busy_next;
            count <= count + CW'(push) - CW'(pop);
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            if (empty || pop)
                wait_cnt <= '0;
            else if (pipe_win && !starve)
                wait_cnt <= wait_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wptr]   <= bus.mdu_rd;
            q_data[wptr] <= bus.mdu_data;
        end
    end
endmodule
